// File: rtl/ar_txd_fifo_pkg.sv
// rtl/ar_txd_fifo_pkg.sv - shared constants, state encodings and word helpers for the ARINC-429 transmitter
package ar_txd_fifo_pkg;

    localparam int WORD_W = 32;
    localparam int FIFO_W = 31;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BIT_HI = 2'd1;
    localparam logic [1:0] ST_BIT_LO = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    function automatic int unsigned rate_of(input logic [1:0] nvel);
        case (nvel)
            2'd0:    return 12_500;
            2'd1:    return 50_000;
            2'd2:    return 100_000;
            default: return 250_000;
        endcase
    endfunction

    function automatic int unsigned half_clks(input int unsigned clk_hz, input logic [1:0] nvel);
        return clk_hz / (2 * rate_of(nvel));
    endfunction

    // Label goes out MSB first, data LSB first, odd parity last; shifted out from bit 31.
    function automatic logic [WORD_W-1:0] build_word(input logic [FIFO_W-1:0] d);
        logic [22:0] r;
        for (int i = 0; i < 23; i++) begin
            r[22-i] = d[i];
        end
        return {d[30:23], r, ~^d};
    endfunction

endpackage

// File: rtl/ar_word_fifo.sv
// rtl/ar_word_fifo.sv - word FIFO with registered full/empty/level flags
module ar_word_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          do_push;
    logic          do_pop;

    // A full FIFO still takes a word when the same edge frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        case ({do_push, do_pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ar_txd_fifo.sv
// rtl/ar_txd_fifo.sv - buffered ARINC-429 bipolar-RZ transmitter with per-word rate latch and inter-word gap
module ar_txd_fifo
    import ar_txd_fifo_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int DEPTH    = 4,
    parameter int GAP_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               Nvel,
    input  logic [7:0]               ADR,
    input  logic [22:0]              DAT,
    input  logic                     st,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     drop,
    output logic                     done,
    output logic                     TXD1,
    output logic                     TXD0
);

    localparam int unsigned H0   = half_clks(CLK_HZ, 2'd0);
    localparam int unsigned H1   = half_clks(CLK_HZ, 2'd1);
    localparam int unsigned H2   = half_clks(CLK_HZ, 2'd2);
    localparam int unsigned H3   = half_clks(CLK_HZ, 2'd3);
    localparam int unsigned GMAX = GAP_BITS * 2 * H0;
    localparam int          CW   = $clog2(GMAX);

    localparam logic [CW-1:0] HM1_0 = CW'(H0 - 1);
    localparam logic [CW-1:0] HM1_1 = CW'(H1 - 1);
    localparam logic [CW-1:0] HM1_2 = CW'(H2 - 1);
    localparam logic [CW-1:0] HM1_3 = CW'(H3 - 1);
    localparam logic [CW-1:0] GM1_0 = CW'(GAP_BITS * 2 * H0 - 1);
    localparam logic [CW-1:0] GM1_1 = CW'(GAP_BITS * 2 * H1 - 1);
    localparam logic [CW-1:0] GM1_2 = CW'(GAP_BITS * 2 * H2 - 1);
    localparam logic [CW-1:0] GM1_3 = CW'(GAP_BITS * 2 * H3 - 1);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [4:0]        bit_cnt;
    logic [WORD_W-1:0] sreg;
    logic [1:0]        nvel_q;
    logic [CW-1:0]     half_m1;
    logic [CW-1:0]     gap_m1;
    logic [FIFO_W-1:0] rd_data;
    logic              pop;

    assign pop = (state == ST_IDLE) && !empty;

    ar_word_fifo #(
        .W     (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (st),
        .wr_data ({ADR, DAT}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_comb begin
        half_m1 = HM1_3;
        gap_m1  = GM1_3;
        case (nvel_q)
            2'd0:    begin half_m1 = HM1_0; gap_m1 = GM1_0; end
            2'd1:    begin half_m1 = HM1_1; gap_m1 = GM1_1; end
            2'd2:    begin half_m1 = HM1_2; gap_m1 = GM1_2; end
            default: begin half_m1 = HM1_3; gap_m1 = GM1_3; end
        endcase
    end

    // Line outputs are registered from the current state, so they trail the FSM by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            nvel_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            drop    <= 1'b0;
            TXD1    <= 1'b0;
            TXD0    <= 1'b0;
        end else begin
            drop <= st && full && !pop;
            done <= 1'b0;
            TXD1 <= (state == ST_BIT_HI) &&  sreg[WORD_W-1];
            TXD0 <= (state == ST_BIT_HI) && !sreg[WORD_W-1];
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        sreg    <= build_word(rd_data);
                        nvel_q  <= Nvel;
                        bit_cnt <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_BIT_HI;
                    end
                end
                ST_BIT_HI: begin
                    if (cnt == half_m1) begin
                        cnt   <= '0;
                        state <= ST_BIT_LO;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BIT_LO: begin
                    if (cnt == half_m1) begin
                        cnt <= '0;
                        if (bit_cnt == 5'd31) begin
                            state <= ST_GAP;
                        end else begin
                            sreg    <= sreg << 1;
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= ST_BIT_HI;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == gap_m1) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ar_txd_fifo.sv
// tb/tb_ar_txd_fifo.sv - scoreboard bench decoding the TXD line pair back into words
module tb_ar_txd_fifo;

    typedef struct {
        logic [31:0] word;
        int          half;
        int          pre;
    } sb_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] Nvel;
    logic [7:0] ADR;
    logic [22:0] DAT;
    logic       st;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       busy;
    logic       drop;
    logic       done;
    logic       TXD1;
    logic       TXD0;

    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];

    logic [31:0] wd;
    int  nbits = 0;
    int  hi_len = 0;
    int  lo_run = 0;
    int  pre_run = 0;
    int  ones = 0;
    int  last_ones = 0;
    int  hi_events = 0;
    logic in_hi = 1'b0;
    logic cur_bit = 1'b0;
    logic len_ok = 1'b1;
    logic both_seen = 1'b0;

    ar_txd_fifo #(
        .CLK_HZ   (1_000_000),
        .DEPTH    (4),
        .GAP_BITS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Nvel  (Nvel),
        .ADR   (ADR),
        .DAT   (DAT),
        .st    (st),
        .full  (full),
        .empty (empty),
        .level (level),
        .busy  (busy),
        .drop  (drop),
        .done  (done),
        .TXD1  (TXD1),
        .TXD0  (TXD0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int half_of(input logic [1:0] nv);
        case (nv)
            2'd0:    return 40;
            2'd1:    return 10;
            2'd2:    return 5;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] a, input logic [22:0] d);
        logic [31:0] w;
        w[31:24] = a;
        for (int i = 0; i < 23; i++) w[23-i] = d[i];
        w[0] = ~(^{a, d});
        return w;
    endfunction

    // Line decoder: rebuilds each word and checks it against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_hi  = 1'b0;
            nbits  = 0;
            lo_run = 0;
            ones   = 0;
            len_ok = 1'b1;
        end else begin
            if (TXD1 && TXD0) both_seen = 1'b1;
            if (TXD1 || TXD0) begin
                if (!in_hi) begin
                    in_hi   = 1'b1;
                    hi_len  = 1;
                    cur_bit = TXD1;
                    hi_events++;
                    if (nbits == 0) pre_run = lo_run;
                    else if (sb.size() > 0 && lo_run != sb[0].half) len_ok = 1'b0;
                end else begin
                    hi_len++;
                end
            end else begin
                if (in_hi) begin
                    in_hi = 1'b0;
                    if (sb.size() > 0 && hi_len != sb[0].half) len_ok = 1'b0;
                    wd = {wd[30:0], cur_bit};
                    ones += int'(cur_bit);
                    nbits++;
                    lo_run = 0;
                    if (nbits == 32) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_word", wd, 32'h0);
                        end else begin
                            sb_t e;
                            e = sb.pop_front();
                            chk("word", wd, e.word);
                            chk("bit_timing", len_ok, 1'b1);
                            chk("word_parity_odd", ones % 2, 1);
                            if (e.pre != 0) chk("inter_word_low", pre_run, e.pre);
                        end
                        last_ones = ones;
                        nbits  = 0;
                        ones   = 0;
                        len_ok = 1'b1;
                    end
                end
                lo_run++;
            end
        end
    end

    initial begin
        int  n;
        sb_t e;
        logic [7:0]  a;
        logic [22:0] d;

        rst_n = 1'b0;
        st    = 1'b0;
        Nvel  = 2'd3;
        ADR   = '0;
        DAT   = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd1",  TXD1,  1'b0);
        chk("rst_txd0",  TXD0,  1'b0);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_full",  full,  1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_level", level, 3'd0);
        chk("rst_drop",  drop,  1'b0);
        chk("rst_done",  done,  1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: single known word at the fastest rate, latency and done timing.
        ADR = 8'h84; DAT = 23'h112200; st = 1'b1;
        e.word = 32'h84004489; e.half = 2; e.pre = 0; sb.push_back(e);
        @(negedge clk); st = 1'b0;
        chk("t1_level1", level, 3'd1);
        chk("t1_txd_e0", TXD1, 1'b0);
        @(negedge clk);
        chk("t1_busy",   busy, 1'b1);
        chk("t1_txd_e1", TXD1, 1'b0);
        @(negedge clk);
        chk("t1_txd1_e2", TXD1, 1'b1);
        chk("t1_txd0_e2", TXD0, 1'b0);
        n = 3;
        while (!done && n < 400) begin @(negedge clk); n++; end
        chk("t1_done_latency", n, 146);
        chk("t1_ones", last_ones, 7);
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_idle", busy, 1'b0);

        // Test 2 + 5: fill while busy, overflow drop, then push at full on the pop edge.
        a = 8'h3C; d = 23'h7F0F0F;
        ADR = a; DAT = d; st = 1'b1;
        e.word = exp_word(a, d); e.half = 2; e.pre = 0; sb.push_back(e);
        @(negedge clk); st = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); d = 23'($urandom);
            ADR = a; DAT = d; st = 1'b1;
            e.word = exp_word(a, d); e.half = 2; e.pre = 19; sb.push_back(e);
            @(negedge clk);
        end
        chk("t2_full",  full,  1'b1);
        chk("t2_level", level, 3'd4);
        ADR = 8'hFF; DAT = 23'h7FFFFF; st = 1'b1;
        @(negedge clk); st = 1'b0;
        chk("t2_drop",       drop,  1'b1);
        chk("t2_level_drop", level, 3'd4);
        @(negedge clk);
        chk("t2_drop_pulse", drop, 1'b0);
        n = 0;
        while (!done && n < 400) begin @(negedge clk); n++; end
        chk("t5_done_seen", done, 1'b1);
        a = 8'hA5; d = 23'h2AAAAA;
        ADR = a; DAT = d; st = 1'b1;
        e.word = exp_word(a, d); e.half = 2; e.pre = 19; sb.push_back(e);
        @(negedge clk); st = 1'b0;
        chk("t5_no_drop", drop,  1'b0);
        chk("t5_level",   level, 3'd4);
        chk("t5_full",    full,  1'b1);
        n = 0;
        while ((busy || !empty || sb.size() != 0) && n < 2000) begin @(negedge clk); n++; end
        chk("t2_drained", sb.size(), 0);
        chk("t2_empty", empty, 1'b1);

        // Test 3: rate change mid-word applies to the next word only.
        Nvel = 2'd0;
        a = 8'h01; d = 23'h000003;
        ADR = a; DAT = d; st = 1'b1;
        e.word = exp_word(a, d); e.half = 40; e.pre = 0; sb.push_back(e);
        @(negedge clk);
        a = 8'hC3; d = 23'h5A5A5A;
        ADR = a; DAT = d;
        e.word = exp_word(a, d); e.half = 2; e.pre = 361; sb.push_back(e);
        @(negedge clk); st = 1'b0;
        repeat (10) @(negedge clk);
        Nvel = 2'd3;
        n = 0;
        while ((busy || !empty || sb.size() != 0) && n < 6000) begin @(negedge clk); n++; end
        chk("t3_drained", sb.size(), 0);

        // Test 4: asynchronous reset in the middle of a word.
        for (int i = 0; i < 2; i++) begin
            ADR = 8'(i + 8'h10); DAT = 23'h123456; st = 1'b1;
            @(negedge clk);
        end
        st = 1'b0;
        n = 0;
        while (nbits != 10 && n < 300) begin @(negedge clk); n++; end
        chk("t4_reached_bit10", nbits, 10);
        #3 rst_n = 1'b0;
        #1;
        chk("t4_txd1",  TXD1,  1'b0);
        chk("t4_txd0",  TXD0,  1'b0);
        chk("t4_busy",  busy,  1'b0);
        chk("t4_empty", empty, 1'b1);
        chk("t4_level", level, 3'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hi_events = 0;
        repeat (100) @(negedge clk);
        chk("t4_silent", hi_events, 0);
        chk("t4_still_idle", busy, 1'b0);

        // Test 6: random words at random rates.
        for (int i = 0; i < 8; i++) begin
            Nvel = 2'($urandom_range(0, 3));
            a = 8'($urandom); d = 23'($urandom);
            ADR = a; DAT = d; st = 1'b1;
            e.word = exp_word(a, d); e.half = half_of(Nvel); e.pre = 0; sb.push_back(e);
            @(negedge clk); st = 1'b0;
            n = 0;
            while (!done && n < 3500) begin @(negedge clk); n++; end
            chk("t6_done", done, 1'b1);
        end
        chk("t6_drained", sb.size(), 0);
        chk("no_overlap", both_seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
